// File: rtl/i2c_reg_bank.sv
// I2C register bank: a pointer byte followed by auto-incrementing data bytes over 2**ADDR_W
// byte registers, with a prefetched transmit byte and a stall handshake to the byte engine.
module i2c_reg_bank #(
  parameter logic [6:0]            I2C_ADDRESS = 7'h42,
  parameter int unsigned           ADDR_W      = 4,
  parameter logic [2**ADDR_W-1:0]  RO_MASK     = '0,
  parameter logic [7:0]            RESET_VAL   = 8'h00
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                i2c_addr_rw,
  input  logic                      i2c_addr_rw_valid_stb,
  input  logic [7:0]                i2c_data_rx,
  input  logic                      i2c_data_rx_valid_stb,
  output logic [7:0]                i2c_data_tx,
  input  logic                      i2c_data_tx_loaded_stb,
  input  logic                      i2c_data_tx_done_stb,
  input  logic                      i2c_error_stb,
  output logic                      stall,
  input  logic [8*(2**ADDR_W)-1:0]  ro_in,
  output logic [8*(2**ADDR_W)-1:0]  regs_flat,
  output logic                      reg_wr_stb,
  output logic [ADDR_W-1:0]         reg_wr_idx,
  output logic [7:0]                reg_wr_data,
  output logic                      reg_rd_stb,
  output logic [ADDR_W-1:0]         reg_rd_idx
);

  localparam int unsigned        NumRegs = 2**ADDR_W;
  localparam logic [ADDR_W-1:0]  PtrOne  = 1;

  typedef enum logic [1:0] {StIdle, StPtr, StWrite, StRead} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                pending_q, pending_d;
  logic [7:0]          tx_q, tx_d;
  logic [7:0]          regs_q [NumRegs];
  logic [7:0]          ro_bytes [NumRegs];
  logic                wr_en;
  logic                wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]   wr_idx_q, wr_idx_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                rd_stb_q, rd_stb_d;
  logic [ADDR_W-1:0]   rd_idx_q, rd_idx_d;

  // Completes the byte-engine interface; a finished shift needs no action here.
  logic unused_tx_done;
  assign unused_tx_done = i2c_data_tx_done_stb;

  for (genvar g = 0; g < NumRegs; g++) begin : g_pack
    assign regs_flat[8*g +: 8] = regs_q[g];
    assign ro_bytes[g]         = ro_in[8*g +: 8];
  end

  assign i2c_data_tx = tx_q;
  assign stall       = pending_q;
  assign reg_wr_stb  = wr_stb_q;
  assign reg_wr_idx  = wr_idx_q;
  assign reg_wr_data = wr_data_q;
  assign reg_rd_stb  = rd_stb_q;
  assign reg_rd_idx  = rd_idx_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pending_d = pending_q;
    tx_d      = tx_q;
    wr_en     = 1'b0;
    wr_stb_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    rd_stb_d  = 1'b0;
    rd_idx_d  = rd_idx_q;

    // Prefetch reads the registers after any write from the previous edge has landed.
    if (pending_q) begin
      tx_d      = RO_MASK[ptr_q] ? ro_bytes[ptr_q] : regs_q[ptr_q];
      pending_d = 1'b0;
    end

    if (i2c_error_stb) begin
      state_d   = StIdle;
      pending_d = 1'b0;
    end else if (i2c_addr_rw_valid_stb) begin
      if (i2c_addr_rw[7:1] == I2C_ADDRESS) begin
        if (i2c_addr_rw[0]) begin
          state_d   = StRead;
          pending_d = 1'b1;
        end else begin
          state_d = StPtr;
        end
      end else begin
        state_d = StIdle;
      end
    end else begin
      unique case (state_q)
        StPtr: begin
          if (i2c_data_rx_valid_stb) begin
            ptr_d     = i2c_data_rx[ADDR_W-1:0];
            pending_d = 1'b1;
            state_d   = StWrite;
          end
        end
        StWrite: begin
          if (i2c_data_rx_valid_stb) begin
            if (!RO_MASK[ptr_q]) begin
              wr_en     = 1'b1;
              wr_stb_d  = 1'b1;
              wr_idx_d  = ptr_q;
              wr_data_d = i2c_data_rx;
            end
            ptr_d     = ptr_q + PtrOne;
            pending_d = 1'b1;
          end
        end
        StRead: begin
          if (i2c_data_tx_loaded_stb) begin
            rd_stb_d  = 1'b1;
            rd_idx_d  = ptr_q;
            ptr_d     = ptr_q + PtrOne;
            pending_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      pending_q <= 1'b0;
      tx_q      <= 8'h00;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= 8'h00;
      rd_stb_q  <= 1'b0;
      rd_idx_q  <= '0;
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      tx_q      <= tx_d;
      wr_stb_q  <= wr_stb_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      rd_stb_q  <= rd_stb_d;
      rd_idx_q  <= rd_idx_d;
      if (wr_en) regs_q[ptr_q] <= i2c_data_rx;
    end
  end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed bench for i2c_reg_bank: expected write/read strobes are queued by the stimulus and
// checked by an independent monitor; register, stall and tx values are checked inline.
module tb_i2c_reg_bank;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   i2c_addr_rw;
  logic         i2c_addr_rw_valid_stb;
  logic [7:0]   i2c_data_rx;
  logic         i2c_data_rx_valid_stb;
  logic [7:0]   i2c_data_tx;
  logic         i2c_data_tx_loaded_stb;
  logic         i2c_data_tx_done_stb;
  logic         i2c_error_stb;
  logic         stall;
  logic [127:0] ro_in;
  logic [127:0] regs_flat;
  logic         reg_wr_stb;
  logic [3:0]   reg_wr_idx;
  logic [7:0]   reg_wr_data;
  logic         reg_rd_stb;
  logic [3:0]   reg_rd_idx;

  typedef struct {logic [3:0] idx; logic [7:0] data;} wr_t;
  wr_t        wr_q[$];
  logic [3:0] rd_q[$];
  int         total = 0;
  int         bad = 0;

  i2c_reg_bank #(
    .I2C_ADDRESS(7'h42),
    .ADDR_W     (4),
    .RO_MASK    (16'h0004),
    .RESET_VAL  (8'h00)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i2c_addr_rw           (i2c_addr_rw),
    .i2c_addr_rw_valid_stb (i2c_addr_rw_valid_stb),
    .i2c_data_rx           (i2c_data_rx),
    .i2c_data_rx_valid_stb (i2c_data_rx_valid_stb),
    .i2c_data_tx           (i2c_data_tx),
    .i2c_data_tx_loaded_stb(i2c_data_tx_loaded_stb),
    .i2c_data_tx_done_stb  (i2c_data_tx_done_stb),
    .i2c_error_stb         (i2c_error_stb),
    .stall                 (stall),
    .ro_in                 (ro_in),
    .regs_flat             (regs_flat),
    .reg_wr_stb            (reg_wr_stb),
    .reg_wr_idx            (reg_wr_idx),
    .reg_wr_data           (reg_wr_data),
    .reg_rd_stb            (reg_rd_stb),
    .reg_rd_idx            (reg_rd_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] reg_of(input int i);
    return regs_flat[8*i +: 8];
  endfunction

  // Scoreboard monitor: every strobe must match the head of its queue.
  always @(negedge clk) begin
    if (reg_wr_stb) begin
      if (wr_q.size() == 0) begin
        check("unexpected_wr_stb", {28'd0, reg_wr_idx}, 32'hffff);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_idx", {28'd0, reg_wr_idx}, {28'd0, e.idx});
        check("wr_data", {24'd0, reg_wr_data}, {24'd0, e.data});
      end
    end
    if (reg_rd_stb) begin
      if (rd_q.size() == 0) begin
        check("unexpected_rd_stb", {28'd0, reg_rd_idx}, 32'hffff);
      end else begin
        logic [3:0] ei;
        ei = rd_q.pop_front();
        check("rd_idx", {28'd0, reg_rd_idx}, {28'd0, ei});
      end
    end
  end

  // Tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_addr(input logic [7:0] b);
    i2c_addr_rw = b;
    i2c_addr_rw_valid_stb = 1'b1;
    idle(1);
    i2c_addr_rw_valid_stb = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    i2c_data_rx = b;
    i2c_data_rx_valid_stb = 1'b1;
    idle(1);
    i2c_data_rx_valid_stb = 1'b0;
    idle(1);
  endtask

  task automatic wr_exp(input logic [3:0] idx, input logic [7:0] data);
    wr_t e;
    e.idx = idx;
    e.data = data;
    wr_q.push_back(e);
  endtask

  task automatic load_tx(input logic [3:0] exp_idx);
    rd_q.push_back(exp_idx);
    i2c_data_tx_loaded_stb = 1'b1;
    idle(1);
    i2c_data_tx_loaded_stb = 1'b0;
    check("stall_after_load", {31'd0, stall}, 32'd1);
    idle(1);
    check("stall_clear_after_load", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    i2c_addr_rw = 8'h00;
    i2c_addr_rw_valid_stb = 1'b0;
    i2c_data_rx = 8'h00;
    i2c_data_rx_valid_stb = 1'b0;
    i2c_data_tx_loaded_stb = 1'b0;
    i2c_data_tx_done_stb = 1'b0;
    i2c_error_stb = 1'b0;
    ro_in = '0;
    ro_in[23:16] = 8'h5C;
    ro_in[31:24] = 8'hE7;
    idle(3);
    check("rst_regs_lo", regs_flat[31:0], 32'h0);
    check("rst_regs_hi", regs_flat[127:96], 32'h0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_tx", {24'd0, i2c_data_tx}, 32'h0);
    check("rst_strobes", {30'd0, reg_wr_stb, reg_rd_stb}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Pointer 3, then AA, BB; repeated-start read must continue at pointer 5.
    send_addr(8'h84);
    send_rx(8'h03);
    wr_exp(4'd3, 8'hAA);
    send_rx(8'hAA);
    wr_exp(4'd4, 8'hBB);
    send_rx(8'hBB);
    check("write_reg3", {24'd0, reg_of(3)}, 32'hAA);
    check("write_reg4", {24'd0, reg_of(4)}, 32'hBB);
    send_addr(8'h85);
    idle(1);
    load_tx(4'd5);

    // Pointer-only write then repeated-start read of 3, 4, 5.
    send_addr(8'h84);
    send_rx(8'h03);
    send_addr(8'h85);
    check("read_entry_stall", {31'd0, stall}, 32'd1);
    idle(1);
    check("read_entry_stall_clear", {31'd0, stall}, 32'd0);
    check("read_tx_3", {24'd0, i2c_data_tx}, 32'hAA);
    load_tx(4'd3);
    check("read_tx_4", {24'd0, i2c_data_tx}, 32'hBB);
    load_tx(4'd4);
    check("read_tx_5", {24'd0, i2c_data_tx}, 32'h00);
    load_tx(4'd5);

    // Pointer wrap and ignored upper pointer bits.
    send_addr(8'h84);
    send_rx(8'h0F);
    wr_exp(4'd15, 8'h11);
    send_rx(8'h11);
    wr_exp(4'd0, 8'h22);
    send_rx(8'h22);
    check("wrap_reg15", {24'd0, reg_of(15)}, 32'h11);
    check("wrap_reg0", {24'd0, reg_of(0)}, 32'h22);
    send_addr(8'h84);
    send_rx(8'h13);
    wr_exp(4'd3, 8'h33);
    send_rx(8'h33);
    check("ptr_upper_ignored_reg3", {24'd0, reg_of(3)}, 32'h33);

    // Read-only register 2: write dropped, pointer still advances, read returns ro_in.
    send_addr(8'h84);
    send_rx(8'h02);
    send_rx(8'h99);
    check("ro_reg2_unchanged", {24'd0, reg_of(2)}, 32'h00);
    send_addr(8'h85);
    idle(1);
    check("ro_ptr_advanced_tx", {24'd0, i2c_data_tx}, 32'h33);
    load_tx(4'd3);
    send_addr(8'h84);
    send_rx(8'h02);
    send_addr(8'h85);
    idle(1);
    check("ro_read_tx", {24'd0, i2c_data_tx}, 32'h5C);
    load_tx(4'd2);

    // Foreign address: nothing happens.
    send_addr(8'h90);
    check("foreign_stall_addr", {31'd0, stall}, 32'd0);
    send_rx(8'h01);
    send_rx(8'h77);
    check("foreign_stall_rx", {31'd0, stall}, 32'd0);
    check("foreign_reg1", {24'd0, reg_of(1)}, 32'h00);
    check("foreign_reg3", {24'd0, reg_of(3)}, 32'h33);

    // Error mid-write aborts; following bytes are ignored.
    send_addr(8'h84);
    send_rx(8'h06);
    i2c_error_stb = 1'b1;
    idle(1);
    i2c_error_stb = 1'b0;
    check("error_clears_stall", {31'd0, stall}, 32'd0);
    send_rx(8'h55);
    send_rx(8'h56);
    check("error_reg6", {24'd0, reg_of(6)}, 32'h00);
    check("error_reg7", {24'd0, reg_of(7)}, 32'h00);

    // Reset mid-read, with a load strobe on the same edge that must not fire.
    send_addr(8'h84);
    send_rx(8'h08);
    wr_exp(4'd8, 8'h66);
    send_rx(8'h66);
    send_addr(8'h84);
    send_rx(8'h08);
    send_addr(8'h85);
    idle(1);
    check("pre_reset_tx", {24'd0, i2c_data_tx}, 32'h66);
    rst_n = 1'b0;
    i2c_data_tx_loaded_stb = 1'b1;
    idle(1);
    i2c_data_tx_loaded_stb = 1'b0;
    check("midrst_regs_lo", regs_flat[63:0] == 64'd0 ? 32'd1 : 32'd0, 32'd1);
    check("midrst_regs_hi", regs_flat[127:64] == 64'd0 ? 32'd1 : 32'd0, 32'd1);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_tx", {24'd0, i2c_data_tx}, 32'h00);
    rst_n = 1'b1;
    idle(3);

    check("wr_queue_drained", wr_q.size(), 32'd0);
    check("rd_queue_drained", rd_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
